cdp_arbiter: RTL and testbench
==============================

CDP_ARBITER -- requirements
Module: cdp_arbiter

Interface
REQ-001 Parameter N, default 8: number of request inputs, legal range 2..256, power of two not required.
REQ-002 Derived width W = ceil(log2(N)): width of the index output, fixed internally, not overridable.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  N  request lines; bit N-1 is the top fixed-priority input; pulse or level.
REQ-006 mode  input  1  arbitration mode: 0 = fixed priority (MSB highest), 1 = round-robin.
REQ-007 ack  input  1  consumer acknowledge of the current grant.
REQ-008 out  output  W  registered index of the granted request.
REQ-009 valid  output  1  registered; high = out holds a live grant.
REQ-010 pend  output  N  registered pending-request vector.

Function
REQ-011 Requests shall be sticky: at each edge, pend <= pend | req, except for the clear in REQ-016.
REQ-012 The FSM shall have exactly two states: IDLE and GRANT.
REQ-013 In IDLE, when (pend | req) != 0, the block shall select a winner from (pend | req), register out = winner and valid = 1, and enter GRANT on the same edge.
- Latency: req high before edge t gives valid = 1 after edge t.
REQ-014 In IDLE with (pend | req) == 0: valid = 0, out holds its previous value, and the FSM stays in IDLE.
REQ-015 In GRANT, out and valid shall stay stable until ack = 1; changes on req or mode in GRANT only update pend.
REQ-016 On an edge in GRANT with ack = 1:
- pend[out] is cleared, unless req[out] = 1 in that cycle (set wins);
- all other req bits still merge into pend;
- valid <= 0 and the FSM returns to IDLE.
REQ-017 One idle cycle (valid = 0) shall always separate consecutive grants; back-to-back arbitration in the ack cycle is not performed.
REQ-018 ack while in IDLE shall be ignored, with no effect on any state.
REQ-019 mode shall be sampled only at the IDLE arbitration edge.
REQ-020 Fixed mode: the winner is the highest-index set bit of (pend | req).
REQ-021 Round-robin mode:
- an internal pointer last holds the index of the most recently acknowledged grant;
- search order is last-1, last-2, ..., 0, N-1, ..., last (downward with wrap);
- the winner is the first set bit in that order.
REQ-022 last shall update only on an acknowledged grant (REQ-016 edge), in both modes.
REQ-023 With N not a power of two, out shall never carry a value >= N, and the wrap goes from 0 to N-1.
REQ-024 A single requester in round-robin mode shall be granted repeatedly, every second cycle while held.

Reset
REQ-025 With rst_n = 0, without waiting for clk, the block shall force:
- out = 0, valid = 0, pend = 0;
- last = 0;
- FSM = IDLE.
REQ-026 Because last resets to 0, the first round-robin search after reset shall start at index N-1, matching fixed priority.
REQ-027 A reset asserted during GRANT shall drop valid immediately and discard all pending requests.
REQ-028 Reset release shall be synchronous-safe: the first arbitration happens at the first rising edge with rst_n = 1.

Verification (N=8)
REQ-029 Reset: rst_n = 0 with clock stopped -> out = 0, valid = 0, pend = 8'h00 immediately.
REQ-030 Fixed mode, one-cycle pulse req = 8'b0010_0100 ->
- next edge: out = 5, valid = 1, pend = 8'b0010_0100;
- ack -> valid = 0 for one cycle;
- then out = 2, valid = 1;
- ack -> valid = 0, pend = 0.
REQ-031 Round-robin mode, req held at 8'b1000_0001 -> grants follow out = 7, 0, 7, 0, each separated by one valid-low cycle.
REQ-032 Hold: grant out = 3, ack held low 10 cycles while req toggles bits 6 and 1 -> out = 3 and valid = 1 stay stable; pend gains bits 6 and 1; after ack the next grant is out = 6.
REQ-033 Collision: req[4] asserted in the same cycle as ack of out = 4 -> pend[4] stays 1 and out = 4 is re-granted after the idle cycle.
REQ-034 Async reset: rst_n pulsed low mid-GRANT between clock edges -> valid = 0 and pend = 0 immediately; no grant until the first edge after release.

Source files
------------

// File: rtl/cdp_arbiter.sv
// cdp_arbiter: sticky-request arbiter with fixed-priority or round-robin
// selection. One grant is presented at a time and held until acknowledged;
// at least one idle cycle always separates consecutive grants.
module cdp_arbiter #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic [W-1:0] out,
  output logic         valid,
  output logic [N-1:0] pend
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]   state;
  logic [W-1:0] last;
  logic [N-1:0] cand;
  logic [W-1:0] fix_win;
  logic [W-1:0] rr_win;
  logic         rr_found;
  logic [W-1:0] win;
  logic [N-1:0] clr_mask;

  // Winner selection over the merged pending/incoming request set.
  always_comb begin
    cand     = pend | req;
    fix_win  = '0;
    rr_win   = '0;
    rr_found = 1'b0;
    // Ascending scan: the highest set index is the last one written.
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i]) fix_win = W'(i);
    end
    // Downward search starting just below last, wrapping N-1 after 0 and
    // ending on last itself so a lone requester is still served.
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned idx;
      idx = (int'(last) + N - k) % N;
      if (!rr_found && cand[idx]) begin
        rr_found = 1'b1;
        rr_win   = W'(idx);
      end
    end
    win = mode ? rr_win : fix_win;
    // Bit of the acknowledged grant is dropped unless re-requested this cycle.
    clr_mask = ({{(N-1){1'b0}}, 1'b1} << out) & ~req;
  end

  // Grant FSM, pending-request register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      out   <= '0;
      valid <= 1'b0;
      pend  <= '0;
      last  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          pend <= cand;
          if (cand != '0) begin
            out   <= win;
            valid <= 1'b1;
            state <= ST_GRANT;
          end else begin
            valid <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (ack) begin
            pend  <= cand & ~clr_mask;
            last  <= out;
            valid <= 1'b0;
            state <= ST_IDLE;
          end else begin
            pend <= cand;
          end
        end
        default: begin
          state <= ST_IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdp_arbiter.sv
// Self-checking bench for cdp_arbiter (N=8): directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_cdp_arbiter;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       mode;
  logic       ack;
  logic [2:0] out;
  logic       valid;
  logic [7:0] pend;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [7:0] m_pend;
  bit       m_valid;
  int       m_out;
  int       m_last;

  cdp_arbiter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .mode  (mode),
    .ack   (ack),
    .out   (out),
    .valid (valid),
    .pend  (pend)
  );

  always #5 clk = clk_en ? ~clk : clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Winner: fixed = highest set index; round-robin = set index at the
  // smallest downward distance from last (distance 0 counts as a full lap).
  function automatic int pick(bit [7:0] c, bit md, int lst);
    int best;
    int bestd;
    int d;
    best = -1;
    bestd = N + 1;
    for (int i = 0; i < N; i++) begin
      if (c[i]) begin
        if (!md) begin
          best = i;
        end else begin
          d = (lst - i + N) % N;
          if (d == 0) d = N;
          if (d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
      end
    end
    return best;
  endfunction

  function automatic void model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_out   = 0;
    m_last  = 0;
  endfunction

  function automatic void model_edge(bit [7:0] r, bit md, bit a);
    bit [7:0] c;
    c = m_pend | r;
    if (!m_valid) begin
      m_pend = c;
      if (c != 0) begin
        m_out   = pick(c, md, m_last);
        m_valid = 1'b1;
      end
    end else if (a) begin
      m_pend = c;
      if (!r[m_out]) m_pend[m_out] = 1'b0;
      m_last  = m_out;
      m_valid = 1'b0;
    end else begin
      m_pend = c;
    end
  endfunction

  // Apply inputs for one cycle, advance the model on the edge, settle.
  task automatic step(input logic [7:0] r, input logic md, input logic a);
    req  = r;
    mode = md;
    ack  = a;
    @(posedge clk);
    model_edge(r, md, a);
    #1;
  endtask

  task automatic do_reset();
    req = '0; mode = 1'b0; ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; mode = 1'b0; ack = 1'b0;
    model_reset();
    #3;
    checks++; if (out !== 3'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL reset_pend: got %02h expected 00", pend); end
    rst_n = 1'b1;
    #1 clk_en = 1'b1;
  endtask

  task automatic test_fixed_pulse();
    do_reset();
    step(8'h24, 1'b0, 1'b0);
    checks++; if (out !== 3'd5 || valid !== 1'b1) begin errors++; $display("FAIL fixed_first: got out=%0d valid=%0b expected out=5 valid=1", out, valid); end
    checks++; if (pend !== 8'h24) begin errors++; $display("FAIL fixed_pend1: got %02h expected 24", pend); end
    step(8'h00, 1'b0, 1'b1);
    checks++; if (valid !== 1'b0 || pend !== 8'h04) begin errors++; $display("FAIL fixed_ack1: got valid=%0b pend=%02h expected valid=0 pend=04", valid, pend); end
    step(8'h00, 1'b0, 1'b0);
    checks++; if (out !== 3'd2 || valid !== 1'b1) begin errors++; $display("FAIL fixed_second: got out=%0d valid=%0b expected out=2 valid=1", out, valid); end
    step(8'h00, 1'b0, 1'b1);
    checks++; if (valid !== 1'b0 || pend !== 8'h00) begin errors++; $display("FAIL fixed_ack2: got valid=%0b pend=%02h expected valid=0 pend=00", valid, pend); end
    step(8'h00, 1'b0, 1'b0);
    checks++; if (out !== 3'd2 || valid !== 1'b0) begin errors++; $display("FAIL idle_hold: got out=%0d valid=%0b expected out=2 valid=0", out, valid); end
  endtask

  task automatic test_rr_alternate();
    int exp_seq[4] = '{7, 0, 7, 0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(8'h81, 1'b1, 1'b0);
      checks++; if (out !== 3'(exp_seq[k]) || valid !== 1'b1) begin errors++; $display("FAIL rr_grant%0d: got out=%0d valid=%0b expected out=%0d valid=1", k, out, valid, exp_seq[k]); end
      step(8'h81, 1'b1, 1'b1);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: got valid=%0b expected 0", k, valid); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    step(8'h08, 1'b0, 1'b0);
    checks++; if (out !== 3'd3 || valid !== 1'b1) begin errors++; $display("FAIL hold_grant: got out=%0d valid=%0b expected out=3 valid=1", out, valid); end
    for (int i = 0; i < 10; i++) begin
      step((i % 2 == 0) ? 8'h42 : 8'h00, i[0], 1'b0);
      checks++; if (out !== 3'd3 || valid !== 1'b1) begin errors++; $display("FAIL hold_stable%0d: got out=%0d valid=%0b expected out=3 valid=1", i, out, valid); end
    end
    checks++; if (pend !== 8'h4a) begin errors++; $display("FAIL hold_pend: got %02h expected 4a", pend); end
    step(8'h00, 1'b0, 1'b1);
    checks++; if (valid !== 1'b0 || pend !== 8'h42) begin errors++; $display("FAIL hold_ack: got valid=%0b pend=%02h expected valid=0 pend=42", valid, pend); end
    step(8'h00, 1'b0, 1'b0);
    checks++; if (out !== 3'd6 || valid !== 1'b1) begin errors++; $display("FAIL hold_next: got out=%0d valid=%0b expected out=6 valid=1", out, valid); end
  endtask

  task automatic test_collision();
    do_reset();
    step(8'h10, 1'b0, 1'b0);
    checks++; if (out !== 3'd4 || valid !== 1'b1) begin errors++; $display("FAIL coll_grant: got out=%0d valid=%0b expected out=4 valid=1", out, valid); end
    step(8'h10, 1'b0, 1'b1);
    checks++; if (valid !== 1'b0 || pend !== 8'h10) begin errors++; $display("FAIL coll_ack: got valid=%0b pend=%02h expected valid=0 pend=10", valid, pend); end
    step(8'h00, 1'b0, 1'b0);
    checks++; if (out !== 3'd4 || valid !== 1'b1) begin errors++; $display("FAIL coll_regrant: got out=%0d valid=%0b expected out=4 valid=1", out, valid); end
    step(8'h00, 1'b0, 1'b1);
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL coll_clear: got %02h expected 00", pend); end
  endtask

  task automatic test_ack_idle();
    do_reset();
    step(8'h00, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    checks++; if (valid !== 1'b0 || pend !== 8'h00) begin errors++; $display("FAIL ackidle_state: got valid=%0b pend=%02h expected valid=0 pend=00", valid, pend); end
    step(8'h81, 1'b1, 1'b0);
    checks++; if (out !== 3'd7 || valid !== 1'b1) begin errors++; $display("FAIL ackidle_rr: got out=%0d valid=%0b expected out=7 valid=1", out, valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(8'h21, 1'b0, 1'b0);
    checks++; if (out !== 3'd5 || valid !== 1'b1) begin errors++; $display("FAIL areset_grant: got out=%0d valid=%0b expected out=5 valid=1", out, valid); end
    req = 8'h00;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (valid !== 1'b0 || pend !== 8'h00 || out !== 3'd0) begin errors++; $display("FAIL areset_immediate: got out=%0d valid=%0b pend=%02h expected 0/0/00", out, valid, pend); end
    req = 8'h21;
    #1 rst_n = 1'b1;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_release: got valid=%0b expected 0", valid); end
    @(posedge clk);
    model_edge(8'h21, 1'b0, 1'b0);
    #1;
    checks++; if (out !== 3'd5 || valid !== 1'b1) begin errors++; $display("FAIL areset_first: got out=%0d valid=%0b expected out=5 valid=1", out, valid); end
  endtask

  task automatic test_random();
    logic [7:0] r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      step(r, 1'($urandom), ($urandom_range(0, 2) == 0));
      checks++;
      if (out !== 3'(m_out) || valid !== m_valid || pend !== m_pend) begin
        errors++;
        $display("FAIL random%0d: got out=%0d valid=%0b pend=%02h expected out=%0d valid=%0b pend=%02h",
                 i, out, valid, pend, m_out, m_valid, m_pend);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_pulse();
    test_rr_alternate();
    test_hold();
    test_collision();
    test_ack_idle();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
